// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with stall hold buffer and branch redirect drain
// Owns the PC, the imem request handshake and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcWrite_en,
  input  logic        IF_ID_write_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        advance;

  assign advance = pcWrite_en & IF_ID_write_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      buf_q        <= 32'h0;
      redir_q      <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      redir_q      <= redir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    redir_d      = redir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    // A flush always wins over a stall; the PC field is left as-is.
    if (branch_taken) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (branch_taken) begin
          if (imem_ready) begin
            pc_d = branch_target;
          end else begin
            redir_d = branch_target;
            state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          if (advance) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (advance) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = S_FETCH;
        end else if (advance) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = buf_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
          state_d      = S_FETCH;
        end
      end
      S_DRAIN: begin
        // The old request must complete before the redirect can be issued.
        if (branch_taken) begin
          redir_d = branch_target;
          if (imem_ready) begin
            pc_d    = branch_target;
            state_d = S_FETCH;
          end
        end else begin
          if (imem_ready) begin
            pc_d    = redir_q;
            state_d = S_FETCH;
          end
          if (advance) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req    = !rst && (state_q != S_HOLD);
  assign imem_addr   = pc_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;

endmodule
